reloj_soc_ram_arbiter: RTL and testbench

RELOJ_SOC_RAM_ARBITER -- requirements
Module: reloj_soc_ram_arbiter

---
 rtl/reloj_soc_ram_arb_pkg.sv | 8 +
 rtl/reloj_soc_rr_arb2.sv | 34 +++
 rtl/reloj_soc_ram_arbiter.sv | 105 ++++++++++
 tb/tb_reloj_soc_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reloj_soc_ram_arb_pkg.sv
// Shared types and constants for the reloj SoC two-master RAM arbiter.
package reloj_soc_ram_arb_pkg;
   localparam int RAM_ADDR_W = 11;
   localparam int RAM_DATA_W = 32;

   typedef enum logic {IDLE = 1'b0, RD_DATA = 1'b1} state_t;
   typedef logic master_idx_t;
endpackage

// File: rtl/reloj_soc_rr_arb2.sv
// Two-requester arbiter: round-robin on a last_grant register by default,
// fixed priority to requester 0 when RELOJ_RAM_ARB_FIXED_PRIO_EN is defined.
module reloj_soc_rr_arb2
   import reloj_soc_ram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   output logic        gnt_vld,
   output master_idx_t gnt_idx
);

`ifdef RELOJ_RAM_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_vld = |req;
      gnt_idx = req[1] & ~req[0];
   end
`else
   master_idx_t last_grant;

   // On contention the master that did not win last time goes first.
   always_comb begin
      gnt_vld = |req;
      if (req == 2'b11) gnt_idx = ~last_grant;
      else              gnt_idx = req[1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     last_grant <= 1'b1;
      else if (gnt_vld) last_grant <= gnt_idx;
   end
`endif

endmodule

// File: rtl/reloj_soc_ram_arbiter.sv
// Two-master single-port RAM arbiter with a one-deep read-return pipeline.
// Define RELOJ_RAM_ARB_FIXED_PRIO_EN for fixed priority to master 0.
module reloj_soc_ram_arbiter
   import reloj_soc_ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   input  logic [DATA_W-1:0]   ram_readdata
);

   logic [1:0]  req_raw;
   logic [1:0]  req;
   logic        gnt_vld;
   master_idx_t gnt_idx;
   logic        gnt_write;
   logic        rd_accept;
   logic        rd_pending;
   state_t      state, state_nxt;
   master_idx_t rd_owner, rd_owner_nxt;

   assign req_raw = {m1_read | m1_write, m0_read | m0_write};
   // Requests are masked while reset is held so the RAM never sees an access.
   assign req     = req_raw & {2{reset_n}};

   reloj_soc_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      gnt_write      = 1'b0;
      if (gnt_vld && gnt_idx) begin
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_writedata  = m1_writedata;
         gnt_write      = m1_write;
      end else if (gnt_vld) begin
         gnt_write      = m0_write;
      end
   end

   assign ram_chipselect = gnt_vld;
   assign ram_write      = gnt_write;
   assign rd_accept      = gnt_vld & ~gnt_write;

   assign m0_waitrequest = req_raw[0] & ~(gnt_vld & (gnt_idx == 1'b0));
   assign m1_waitrequest = req_raw[1] & ~(gnt_vld & (gnt_idx == 1'b1));

   // Read-return stage: RAM data arrives one cycle after the address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rd_owner <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_owner <= rd_owner_nxt;
      end
   end

   always_comb begin
      state_nxt    = IDLE;
      rd_owner_nxt = rd_owner;
      if (rd_accept) begin
         state_nxt    = RD_DATA;
         rd_owner_nxt = gnt_idx;
      end
   end

   assign rd_pending       = (state == RD_DATA);
   assign m0_readdatavalid = rd_pending & (rd_owner == 1'b0);
   assign m1_readdatavalid = rd_pending & (rd_owner == 1'b1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_reloj_soc_ram_arbiter.sv
// Self-checking bench for reloj_soc_ram_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_reloj_soc_ram_arbiter;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int BW = DW/8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] m0_address, m1_address, ram_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable, ram_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata, ram_writedata;
   logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [DW-1:0] m0_readdata, m1_readdata, ram_readdata;
   logic          ram_chipselect, ram_write;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int            mdl_last;
   bit            mdl_pend;
   int            mdl_owner;
   logic [DW-1:0] mdl_pdata;
   logic [DW-1:0] exp_mem [0:2047];
   bit            exp_cs, exp_wr, exp_wait0, exp_wait1, exp_rdv0, exp_rdv1;
   int            exp_gnt;
   logic [AW-1:0] exp_addr;
   logic [BW-1:0] exp_be;
   logic [DW-1:0] exp_wd, exp_rdata;

   always #5 clk = ~clk;

   reloj_soc_ram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
   );

   // Synchronous RAM with byte lanes and one-cycle read latency
   logic [DW-1:0] ram_mem [0:2047];
   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < BW; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= ram_mem[ram_address];
         end
      end
   end

   task automatic clear_inputs();
      m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      clear_inputs();
      mdl_pend = 1'b0;
      mdl_last = 1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One bus cycle: drive at the falling edge, then predict the outcome from the access rules.
   task automatic tick(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [BW-1:0] be0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [BW-1:0] be1, input logic [DW-1:0] d1);
      logic [AW-1:0] ga;
      logic [BW-1:0] gbe;
      logic [DW-1:0] gd;
      logic          gw;
      bit            q0, q1;
      @(negedge clk);
      exp_rdv0  = mdl_pend && (mdl_owner == 0);
      exp_rdv1  = mdl_pend && (mdl_owner == 1);
      exp_rdata = mdl_pdata;
      m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
      m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
      #1;
      q0 = r0 || w0;
      q1 = r1 || w1;
      exp_cs = reset_n && (q0 || q1);
      if (q0 && q1) begin
`ifdef RELOJ_RAM_ARB_FIXED_PRIO_EN
         exp_gnt = 0;
`else
         exp_gnt = 1 - mdl_last;
`endif
      end else begin
         exp_gnt = q1 ? 1 : 0;
      end
      ga  = (exp_gnt == 1) ? a1 : a0;
      gbe = (exp_gnt == 1) ? be1 : be0;
      gd  = (exp_gnt == 1) ? d1 : d0;
      gw  = (exp_gnt == 1) ? w1 : w0;
      exp_wait0 = q0 && !(exp_cs && exp_gnt == 0);
      exp_wait1 = q1 && !(exp_cs && exp_gnt == 1);
      exp_wr    = exp_cs && gw;
      exp_addr  = exp_cs ? ga : a0;
      exp_be    = exp_cs ? gbe : be0;
      exp_wd    = exp_cs ? gd : d0;
      mdl_pend  = 1'b0;
      if (exp_cs) begin
         mdl_last = exp_gnt;
         if (gw) begin
            for (int b = 0; b < BW; b++)
               if (gbe[b]) exp_mem[ga][8*b +: 8] = gd[8*b +: 8];
         end else begin
            mdl_pend  = 1'b1;
            mdl_owner = exp_gnt;
            mdl_pdata = exp_mem[ga];
         end
      end
   endtask

   task automatic idle_tick();
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      m0_read = 1'b1; m0_write = 1'b1;
      #1;
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_wait0: got %b want 1", m0_waitrequest); end
      vectors++; if (m1_waitrequest !== 1'b0) begin miscompares++; $display("FAIL rst_wait1: got %b want 0", m1_waitrequest); end
      vectors++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin miscompares++; $display("FAIL rst_ram: cs %b wr %b want 0 0", ram_chipselect, ram_write); end
      vectors++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rst_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
      clear_inputs();
      mdl_pend = 1'b0;
      mdl_last = 1;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      tick(1'b0, 1'b1, 11'h005, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, '0);
      vectors++; if (ram_chipselect !== 1'b1 || ram_write !== 1'b1) begin miscompares++; $display("FAIL wr_ram: cs %b wr %b want 1 1", ram_chipselect, ram_write); end
      vectors++; if (ram_address !== 11'h005 || m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL wr_addr: got %h/%b want 005/0", ram_address, m0_waitrequest); end
      tick(1'b1, 1'b0, 11'h005, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
      vectors++; if (ram_write !== 1'b0 || m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rd_issue: wr %b rdv %b want 0 0", ram_write, m0_readdatavalid); end
      idle_tick();
      vectors++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_return: rdv %b data %h want 1 deadbeef", m0_readdatavalid, m0_readdata); end
      vectors++; if (m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rd_other: got %b want 0", m1_readdatavalid); end
      idle_tick();
      vectors++; if (m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL rd_once: got %b want 0", m0_readdatavalid); end
   endtask

   task automatic test_byte_lanes();
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 11'h7FF, 4'hF, 32'h11223344);
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 11'h7FF, 4'h8, 32'hAA000000);
      vectors++; if (ram_byteenable !== 4'h8 || ram_writedata !== 32'hAA000000) begin miscompares++; $display("FAIL be_drive: be %h wd %h want 8 aa000000", ram_byteenable, ram_writedata); end
      tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 11'h7FF, 4'hF, '0);
      idle_tick();
      vectors++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hAA223344) begin miscompares++; $display("FAIL be_read: rdv %b data %h want 1 aa223344", m1_readdatavalid, m1_readdata); end
      vectors++; if (m0_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL be_other: got %b want 0", m0_readdatavalid); end
   endtask

   task automatic test_contention();
      int g, prev;
      apply_reset();
      prev = -1;
      for (int k = 0; k < 7; k++) begin
         if (k < 6) tick(1'b1, 1'b0, 11'h005, 4'hF, '0, 1'b1, 1'b0, 11'h7FF, 4'hF, '0);
         else       idle_tick();
`ifdef RELOJ_RAM_ARB_FIXED_PRIO_EN
         g = 0;
`else
         g = k % 2;
`endif
         if (k < 6) begin
            vectors++; if (ram_address !== ((g == 1) ? 11'h7FF : 11'h005)) begin miscompares++; $display("FAIL cont_addr[%0d]: got %h want grant m%0d", k, ram_address, g); end
            vectors++; if (m0_waitrequest !== (g == 1) || m1_waitrequest !== (g == 0)) begin miscompares++; $display("FAIL cont_wait[%0d]: got %b%b want m%0d granted", k, m0_waitrequest, m1_waitrequest, g); end
         end
         if (prev >= 0) begin
            vectors++; if (m0_readdatavalid !== (prev == 0) || m1_readdatavalid !== (prev == 1)) begin miscompares++; $display("FAIL cont_rdv[%0d]: got %b%b want m%0d", k, m0_readdatavalid, m1_readdatavalid, prev); end
            vectors++; if (m0_readdata !== ((prev == 1) ? 32'hAA223344 : 32'hDEADBEEF)) begin miscompares++; $display("FAIL cont_data[%0d]: got %h", k, m0_readdata); end
         end
         prev = g;
      end
   endtask

   task automatic test_reset_mid_read();
      idle_tick();
      tick(1'b1, 1'b0, 11'h005, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      clear_inputs();
      mdl_pend = 1'b0;
      mdl_last = 1;
      m0_read = 1'b1; m0_write = 1'b1;
      #1;
      vectors++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
      vectors++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0 || m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL mid_rst_bus: cs %b wr %b wait %b want 0 0 1", ram_chipselect, ram_write, m0_waitrequest); end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         idle_tick();
         vectors++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin miscompares++; $display("FAIL mid_post_rdv[%0d]: got %b%b want 00", k, m0_readdatavalid, m1_readdatavalid); end
      end
      tick(1'b1, 1'b0, 11'h005, 4'hF, '0, 1'b1, 1'b0, 11'h7FF, 4'hF, '0);
      vectors++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || ram_address !== 11'h005) begin miscompares++; $display("FAIL mid_first_grant: wait %b%b addr %h want 01 005", m0_waitrequest, m1_waitrequest, ram_address); end
      idle_tick();
   endtask

   task automatic test_idle();
      logic [AW-1:0] a;
      for (int k = 0; k < 10; k++) begin
         a = AW'($urandom_range(0, 2047));
         tick(1'b0, 1'b0, a, 4'h5, 32'h0, 1'b0, 1'b0, ~a, 4'hA, 32'h1);
         vectors++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0 || ram_address !== a) begin miscompares++; $display("FAIL idle_ram[%0d]: cs %b wr %b addr %h want 0 0 %h", k, ram_chipselect, ram_write, ram_address, a); end
         vectors++; if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 4'b0000) begin miscompares++; $display("FAIL idle_ctl[%0d]: got %b%b%b%b want 0000", k, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid); end
      end
   endtask

   task automatic test_random();
      logic r0, w0, r1, w1;
      for (int a = 0; a < 16; a++) tick(1'b0, 1'b1, AW'(a), 4'hF, $urandom, 1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 300; k++) begin
         r0 = ($urandom_range(0, 99) < 55); w0 = ($urandom_range(0, 99) < 25);
         r1 = ($urandom_range(0, 99) < 55); w1 = ($urandom_range(0, 99) < 25);
         tick(r0, w0, AW'($urandom_range(0, 15)), BW'($urandom), $urandom,
              r1, w1, AW'($urandom_range(0, 15)), BW'($urandom), $urandom);
         vectors++; if (m0_waitrequest !== exp_wait0 || m1_waitrequest !== exp_wait1) begin miscompares++; $display("FAIL rnd_wait[%0d]: got %b%b want %b%b", k, m0_waitrequest, m1_waitrequest, exp_wait0, exp_wait1); end
         vectors++; if (ram_chipselect !== exp_cs || ram_write !== exp_wr) begin miscompares++; $display("FAIL rnd_ctl[%0d]: cs %b wr %b want %b %b", k, ram_chipselect, ram_write, exp_cs, exp_wr); end
         vectors++; if (ram_address !== exp_addr || ram_byteenable !== exp_be || ram_writedata !== exp_wd) begin miscompares++; $display("FAIL rnd_bus[%0d]: %h/%h/%h want %h/%h/%h", k, ram_address, ram_byteenable, ram_writedata, exp_addr, exp_be, exp_wd); end
         vectors++; if (m0_readdatavalid !== exp_rdv0 || m1_readdatavalid !== exp_rdv1) begin miscompares++; $display("FAIL rnd_rdv[%0d]: got %b%b want %b%b", k, m0_readdatavalid, m1_readdatavalid, exp_rdv0, exp_rdv1); end
         if (exp_rdv0 || exp_rdv1) begin
            vectors++; if (m0_readdata !== exp_rdata || m1_readdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h/%h want %h", k, m0_readdata, m1_readdata, exp_rdata); end
         end
      end
      idle_tick();
   endtask

`ifdef RELOJ_RAM_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b0, 11'h005, 4'hF, '0, 1'b1, 1'b0, 11'h7FF, 4'hF, '0);
         vectors++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || ram_address !== 11'h005) begin miscompares++; $display("FAIL fixed[%0d]: wait %b%b addr %h want 01 005", k, m0_waitrequest, m1_waitrequest, ram_address); end
      end
      idle_tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      clear_inputs();
      mdl_pend = 1'b0;
      mdl_last = 1;
      mdl_owner = 0;
      mdl_pdata = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_contention();
      test_reset_mid_read();
      test_idle();
      test_random();
`ifdef RELOJ_RAM_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
